pe_mac: RTL and testbench
=========================

// Module: pe_mac
// PURPOSE
//  Next-generation processing element for the CNN datapath: a LANES-wide dot product (data x weight) added to an incoming partial sum.
//  Replaces the fixed 8x8 single-lane PE; the multiplier pipeline is built in, not vendor IP.
//  Adds a valid/ready handshake with backpressure, signed/unsigned operands and a local accumulate mode for output-stationary dataflow.
//  Sits in the PE array between the operand broadcast network and the psum chain/output buffer.
// PARAMETERS
//  WIDTH        8   operand width per lane (data, weight)
//  LANES        4   parallel multiply lanes per PE, >=1
//  PSUM_WIDTH   24  psum/accumulator width, >= 2*WIDTH+clog2(LANES)
//  MULT_STAGES  2   register stages inside each lane multiplier, >=1
// PORTS
//  clk        in   1                 clock
//  rst        in   1                 synchronous reset, ACTIVE-LOW (rst==0 resets)
//  cfg_mode   in   1                 0=PASS, 1=ACCUM; change only while busy==0
//  cfg_signed in   1                 1=two's-complement operands/psum; change only while busy==0
//  in_data    in   LANES*WIDTH       lane i at [i*WIDTH +: WIDTH]
//  in_weight  in   LANES*WIDTH       lane i at [i*WIDTH +: WIDTH]
//  in_psum    in   PSUM_WIDTH        partial sum for this beat
//  in_last    in   1                 ACCUM: final beat of accumulation group; ignored in PASS
//  in_vld     in   1                 beat valid
//  in_rdy     out  1                 beat accepted when in_vld&&in_rdy
//  out_psum   out  PSUM_WIDTH        result
//  out_vld    out  1                 result valid
//  out_rdy    in   1                 downstream accepts when out_vld&&out_rdy
//  out_ovf    out  1                 overflow flag with result (only under PE_MAC_SAT_EN, else 0)
//  busy       out  1                 any beat in flight, out_vld high, or ACCUM group open
// BEHAVIOUR
//  - Reset (rst==0 at posedge): all stage valids, out_vld, out_ovf, busy, in-group flag and accumulator -> 0; out_psum -> 0. Mid-operation reset drops all in-flight beats and any open group.
//  - Pipeline: S0 operand regs -> MULT_STAGES mult -> 1 adder-tree stage -> 1 psum/acc stage (output reg). Latency accept->out_vld = MULT_STAGES+2 cycles (4 at defaults).
//  - Flow control: global enable adv = !out_vld || out_rdy; in_rdy = adv; all stages (valids and in_psum/in_last sidebands) shift only when adv. Bubbles are not squeezed. out_psum/out_vld stay stable while out_vld && !out_rdy.
//  - Arithmetic: per-lane product 2*WIDTH, signed or unsigned per cfg_signed; adder tree sums LANES products at 2*WIDTH+clog2(LANES); result sign-/zero-extends to PSUM_WIDTH. Adds wrap modulo 2^PSUM_WIDTH.
//  - PASS: each beat produces out_psum = in_psum + dot.
//  - ACCUM: two states IDLE/OPEN. A beat in IDLE seeds acc = in_psum + dot. A beat in OPEN does acc += dot and ignores in_psum. Non-last beats produce no output and leave/enter OPEN. A beat with in_last outputs the final sum and returns to IDLE. A single-beat group (in_last in IDLE) outputs in_psum + dot.
//  - Simultaneous: output handoff and new accept in the same cycle are legal. An ACCUM last beat arriving at the final stage while out_vld && !out_rdy stalls like any other beat.
//  - cfg change while busy==1: undefined; bench asserts against it.
// CONFIGURATION
//  PE_MAC_SAT_EN defined: the final psum/acc add saturates instead of wrapping. Bounds are signed [-2^(PSUM_WIDTH-1), 2^(PSUM_WIDTH-1)-1] or unsigned [0, 2^PSUM_WIDTH-1] per cfg_signed. ACCUM saturates every step. out_ovf = 1 with any result that saturated at any step of its group.
//  PE_MAC_SAT_EN undefined: wrap-around add; out_ovf tied 0; no saturation logic.
// STRUCTURE
//  - pe_pkg holds: MODE_PASS/MODE_ACCUM constants, the clog2 function, the dot-width function (2*WIDTH+clog2(LANES)), and the sat-bound helpers.
//  - One sub-module, pe_mult_pipe: WIDTH x WIDTH signed/unsigned multiplier with MULT_STAGES registers and enable input. Instantiated LANES times via generate.
//  - Adder tree, accumulator FSM and handshake live in pe_mac.
// TESTING (WIDTH=8, LANES=4, PSUM_WIDTH=24, MULT_STAGES=2)
//  1. PASS unsigned, data {1,2,3,4}, w {5,6,7,8}, psum 100 -> out_psum 170, out_vld exactly 4 cycles after accept.
//  2. PASS signed, data {-1,-2,3,4}, w {5,6,7,8}, psum -10 -> out_psum 26 (0x00001A).
//  3. ACCUM, 3 beats of the #1 operands, psum 5 on beat 1 (ignored 999 on beats 2-3), in_last on beat 3 -> one result 215; out_vld never high for beats 1-2.
//  4. Backpressure: 6 back-to-back PASS beats, out_rdy low 5 cycles mid-stream -> in_rdy low while stalled, out_psum held stable, all 6 results in order, none lost or duplicated.
//  5. Signed PASS, psum 0x7FFFFF, dot 1 -> 0x800000 with out_ovf=0 (macro off); 0x7FFFFF with out_ovf=1 (PE_MAC_SAT_EN).
//  6. Reset mid-ACCUM: 2 beats accepted, rst=0 for 1 cycle -> out_vld=0, busy=0; a next single last beat (dot 70, psum 0) -> out_psum 70.

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg: shared definitions for the pe_mac processing element.
//   MODE_PASS / MODE_ACCUM : values of cfg_mode
//   acc_state_t            : accumulation group state (IDLE / OPEN)
//   clog2, dot_width       : elaboration-time width helpers
//   sat_hi, sat_lo         : saturation bounds for a psum of a given width,
//                            returned in 64 bits (callers size-cast them down;
//                            valid for widths up to 63)
package pe_pkg;

  localparam logic MODE_PASS  = 1'b0;
  localparam logic MODE_ACCUM = 1'b1;

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_OPEN = 1'b1
  } acc_state_t;

  // Ceiling log2; clog2(1) == 0 so a single-lane PE adds no tree growth bits.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Width of the lane-product sum: one full product plus carry growth.
  function automatic int dot_width(input int width, input int lanes);
    return 2 * width + clog2(lanes);
  endfunction

  function automatic logic [63:0] sat_hi(input logic is_signed, input int width);
    if (is_signed) begin
      return (64'd1 << (width - 1)) - 64'd1;
    end
    return (64'd1 << width) - 64'd1;
  endfunction

  // Signed minimum is 1 followed by zeros in the low 'width' bits.
  function automatic logic [63:0] sat_lo(input logic is_signed, input int width);
    if (is_signed) begin
      return ~64'd0 << (width - 1);
    end
    return 64'd0;
  endfunction

endpackage

// File: rtl/pe_mult_pipe.sv
// pe_mult_pipe: WIDTH x WIDTH multiplier with STAGES output registers.
// Operands are sign- or zero-extended to the product width before the
// multiply, so a single unsigned multiplier serves both modes (the low
// 2*WIDTH bits of the product are correct either way).
// Ports:
//   clk        clock
//   rst        synchronous reset, active low
//   en         pipeline advance; all stage registers hold when low
//   is_signed  1 = two's-complement operands
//   a, b       operands
//   p          product, STAGES cycles (of en) after a/b were presented
module pe_mult_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   p
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] prod;
  logic [PW-1:0] stage_reg [STAGES];

  always_comb begin
    a_ext = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
    b_ext = {{WIDTH{is_signed & b[WIDTH-1]}}, b};
    prod  = a_ext * b_ext;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_reg[k] <= '0;
      end
    end else if (en) begin
      stage_reg[0] <= prod;
      for (int k = 1; k < STAGES; k++) begin
        stage_reg[k] <= stage_reg[k-1];
      end
    end
  end

  assign p = stage_reg[STAGES-1];

endmodule

// File: rtl/pe_mac.sv
// pe_mac: LANES-wide dot product (data x weight) added to a partial sum,
// with valid/ready flow control and an optional local accumulate mode.
// Pipeline: S0 operand regs -> MULT_STAGES multiplier regs -> adder-tree reg
// -> psum/acc output reg. Latency accept -> out_vld is MULT_STAGES+2.
// The whole pipeline advances on a single enable (no bubble squeezing).
// Build option: define PE_MAC_SAT_EN to make the final add saturate and
// drive out_ovf; otherwise the add wraps and out_ovf is 0.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   cfg_mode, cfg_signed     PASS/ACCUM and operand signedness (static while busy)
//   in_data, in_weight       lane i at [i*WIDTH +: WIDTH]
//   in_psum, in_last         partial sum and ACCUM group terminator
//   in_vld, in_rdy           input handshake
//   out_psum, out_ovf        result and saturation flag
//   out_vld, out_rdy         output handshake
//   busy                     beat in flight, result pending or group open
module pe_mac
  import pe_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int LANES       = 4,
  parameter int PSUM_WIDTH  = 24,
  parameter int MULT_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_mode,
  input  logic                     cfg_signed,
  input  logic [LANES*WIDTH-1:0]   in_data,
  input  logic [LANES*WIDTH-1:0]   in_weight,
  input  logic [PSUM_WIDTH-1:0]    in_psum,
  input  logic                     in_last,
  input  logic                     in_vld,
  output logic                     in_rdy,
  output logic [PSUM_WIDTH-1:0]    out_psum,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic                     out_ovf,
  output logic                     busy
);

  localparam int DOT_W    = dot_width(WIDTH, LANES);
  // Sideband stages: S0, one per multiplier register, adder tree.
  localparam int SB       = MULT_STAGES + 2;
  localparam int TREE_IDX = SB - 1;

  logic adv;
  logic out_vld_reg;
  logic [PSUM_WIDTH-1:0] out_psum_reg;

  assign adv    = !out_vld_reg || out_rdy;
  assign in_rdy = adv;

  // ---------------- S0 and sideband pipeline ----------------
  logic [LANES*WIDTH-1:0] data_reg;
  logic [LANES*WIDTH-1:0] weight_reg;
  logic                   sb_vld_reg  [SB];
  logic [PSUM_WIDTH-1:0]  sb_psum_reg [SB];
  logic                   sb_last_reg [SB];
  logic [DOT_W-1:0]       tree_sum;
  logic [DOT_W-1:0]       tree_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_reg   <= '0;
      weight_reg <= '0;
      tree_reg   <= '0;
      for (int k = 0; k < SB; k++) begin
        sb_vld_reg[k]  <= 1'b0;
        sb_psum_reg[k] <= '0;
        sb_last_reg[k] <= 1'b0;
      end
    end else if (adv) begin
      // in_rdy == adv, so in_vld alone marks an accepted beat here.
      data_reg       <= in_data;
      weight_reg     <= in_weight;
      sb_vld_reg[0]  <= in_vld;
      sb_psum_reg[0] <= in_psum;
      sb_last_reg[0] <= in_last;
      for (int k = 1; k < SB; k++) begin
        sb_vld_reg[k]  <= sb_vld_reg[k-1];
        sb_psum_reg[k] <= sb_psum_reg[k-1];
        sb_last_reg[k] <= sb_last_reg[k-1];
      end
      tree_reg <= tree_sum;
    end
  end

  // ---------------- lane multipliers ----------------
  logic [2*WIDTH-1:0] lane_prod [LANES];
  logic [DOT_W-1:0]   lane_ext  [LANES];

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      pe_mult_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (MULT_STAGES)
      ) u_mult (
        .clk       (clk),
        .rst       (rst),
        .en        (adv),
        .is_signed (cfg_signed),
        .a         (data_reg[gi*WIDTH +: WIDTH]),
        .b         (weight_reg[gi*WIDTH +: WIDTH]),
        .p         (lane_prod[gi])
      );
      assign lane_ext[gi] = cfg_signed ? DOT_W'($signed(lane_prod[gi]))
                                       : DOT_W'(lane_prod[gi]);
    end
  endgenerate

  always_comb begin
    tree_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      tree_sum = tree_sum + lane_ext[k];
    end
  end

  // ---------------- final psum / accumulator stage ----------------
  logic                  fin_vld;
  logic                  fin_last;
  logic [PSUM_WIDTH-1:0] fin_psum;
  logic [PSUM_WIDTH-1:0] dot_ext;
  logic [PSUM_WIDTH-1:0] acc_reg;
  logic [PSUM_WIDTH-1:0] add_base;
  logic [PSUM_WIDTH-1:0] sum_val;
  acc_state_t            state_reg;
  acc_state_t            state_next;
  logic                  use_acc;
  logic                  out_load;
  logic                  acc_load;

  assign fin_vld  = sb_vld_reg[TREE_IDX];
  assign fin_last = sb_last_reg[TREE_IDX];
  assign fin_psum = sb_psum_reg[TREE_IDX];
  assign dot_ext  = cfg_signed ? PSUM_WIDTH'($signed(tree_reg))
                               : PSUM_WIDTH'(tree_reg);

  always_comb begin
    state_next = state_reg;
    out_load   = 1'b0;
    acc_load   = 1'b0;
    use_acc    = (cfg_mode == MODE_ACCUM) && (state_reg == ACC_OPEN);
    if (adv && fin_vld) begin
      if (cfg_mode == MODE_PASS) begin
        out_load = 1'b1;
      end else if (fin_last) begin
        out_load   = 1'b1;
        state_next = ACC_IDLE;
      end else begin
        acc_load   = 1'b1;
        state_next = ACC_OPEN;
      end
    end
  end

  // An open group continues from the accumulator and ignores in_psum.
  assign add_base = use_acc ? acc_reg : fin_psum;

`ifdef PE_MAC_SAT_EN
  logic [PSUM_WIDTH:0]   sum_wide;
  logic [PSUM_WIDTH-1:0] lim_hi;
  logic [PSUM_WIDTH-1:0] lim_lo;
  logic                  sat_hit;
  logic                  grp_ovf;
  logic                  out_ovf_reg;
  logic                  acc_ovf_reg;

  // One extra bit makes the sum exact; its top two bits reveal overflow.
  always_comb begin
    sum_wide = {cfg_signed & add_base[PSUM_WIDTH-1], add_base}
             + {cfg_signed & dot_ext[PSUM_WIDTH-1], dot_ext};
    lim_hi   = PSUM_WIDTH'(sat_hi(cfg_signed, PSUM_WIDTH));
    lim_lo   = PSUM_WIDTH'(sat_lo(cfg_signed, PSUM_WIDTH));
    sum_val  = sum_wide[PSUM_WIDTH-1:0];
    sat_hit  = 1'b0;
    if (cfg_signed) begin
      if (sum_wide[PSUM_WIDTH] != sum_wide[PSUM_WIDTH-1]) begin
        sat_hit = 1'b1;
        sum_val = sum_wide[PSUM_WIDTH] ? lim_lo : lim_hi;
      end
    end else if (sum_wide[PSUM_WIDTH]) begin
      // Unsigned dot is never negative, so only the upper bound can trip.
      sat_hit = 1'b1;
      sum_val = lim_hi;
    end
  end

  // Sticky across the group: a saturated intermediate taints the result.
  assign grp_ovf = sat_hit | (use_acc & acc_ovf_reg);
  assign out_ovf = out_ovf_reg;
`else
  assign sum_val = add_base + dot_ext;
  assign out_ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= ACC_IDLE;
      acc_reg      <= '0;
      out_psum_reg <= '0;
      out_vld_reg  <= 1'b0;
`ifdef PE_MAC_SAT_EN
      out_ovf_reg  <= 1'b0;
      acc_ovf_reg  <= 1'b0;
`endif
    end else if (adv) begin
      state_reg   <= state_next;
      out_vld_reg <= out_load;
      if (out_load) begin
        out_psum_reg <= sum_val;
      end
      if (acc_load) begin
        acc_reg <= sum_val;
      end
`ifdef PE_MAC_SAT_EN
      out_ovf_reg <= out_load & grp_ovf;
      if (acc_load) begin
        acc_ovf_reg <= grp_ovf;
      end
`endif
    end
  end

  assign out_psum = out_psum_reg;
  assign out_vld  = out_vld_reg;

  logic pipe_any;
  always_comb begin
    pipe_any = 1'b0;
    for (int k = 0; k < SB; k++) begin
      pipe_any = pipe_any | sb_vld_reg[k];
    end
  end

  assign busy = pipe_any || out_vld_reg || (state_reg == ACC_OPEN);

endmodule

// File: tb/tb_pe_mac.sv
// tb_pe_mac: self-checking bench for pe_mac at WIDTH=8, LANES=4,
// PSUM_WIDTH=24, MULT_STAGES=2. Directed cases plus randomized traffic,
// every output compared against an arithmetic reference model.
// Honors PE_MAC_SAT_EN for saturating expectations.
module tb_pe_mac;

  logic        clk;
  logic        rst;
  logic        cfg_mode;
  logic        cfg_signed;
  logic [31:0] in_data;
  logic [31:0] in_weight;
  logic [23:0] in_psum;
  logic        in_last;
  logic        in_vld;
  logic        in_rdy;
  logic [23:0] out_psum;
  logic        out_vld;
  logic        out_rdy;
  logic        out_ovf;
  logic        busy;

  pe_mac #(
    .WIDTH       (8),
    .LANES       (4),
    .PSUM_WIDTH  (24),
    .MULT_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_mode   (cfg_mode),
    .cfg_signed (cfg_signed),
    .in_data    (in_data),
    .in_weight  (in_weight),
    .in_psum    (in_psum),
    .in_last    (in_last),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .out_psum   (out_psum),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_ovf    (out_ovf),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [23:0] psum;
    bit          ovf;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] got_q[$];
  bit          got_ovf_q[$];
  bit          mdl_open = 1'b0;
  logic [23:0] mdl_acc  = '0;
  bit          mdl_ovf  = 1'b0;

  function automatic longint sval(input logic [23:0] x, input bit s);
    if (s) return longint'($signed(x));
    return longint'(x);
  endfunction

  function automatic longint dotm(input logic [31:0] d, input logic [31:0] w, input bit s);
    longint acc;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      if (s) acc += longint'($signed(d[i*8 +: 8])) * longint'($signed(w[i*8 +: 8]));
      else   acc += longint'(d[i*8 +: 8]) * longint'(w[i*8 +: 8]);
    end
    return acc;
  endfunction

  function automatic exp_t addm(input longint base, input longint dot, input bit s);
    exp_t   e;
    longint sum;
    sum   = base + dot;
    e.ovf = 1'b0;
`ifdef PE_MAC_SAT_EN
    begin
      longint lo, hi;
      lo = s ? -64'sd8388608 : 64'sd0;
      hi = s ? 64'sd8388607 : 64'sd16777215;
      if (sum > hi) begin
        sum = hi; e.ovf = 1'b1;
      end else if (sum < lo) begin
        sum = lo; e.ovf = 1'b1;
      end
    end
`endif
    e.psum = sum[23:0];
    return e;
  endfunction

  task automatic model_accept();
    longint dot, base;
    exp_t   e;
    dot = dotm(in_data, in_weight, cfg_signed);
    if (cfg_mode == 1'b0) begin
      exp_q.push_back(addm(sval(in_psum, cfg_signed), dot, cfg_signed));
    end else begin
      base  = mdl_open ? sval(mdl_acc, cfg_signed) : sval(in_psum, cfg_signed);
      e     = addm(base, dot, cfg_signed);
      e.ovf = e.ovf | (mdl_open & mdl_ovf);
      if (in_last) begin
        exp_q.push_back(e);
        mdl_open = 1'b0;
      end else begin
        mdl_acc  = e.psum;
        mdl_ovf  = e.ovf;
        mdl_open = 1'b1;
      end
    end
  endtask

  // ---------------- monitor (negedge: what the next posedge will see) -------
  bit          prev_stall = 1'b0;
  logic [23:0] prev_psum  = '0;
  logic [1:0]  prev_cfg   = 2'b00;

  always @(negedge clk) begin
    if ({cfg_mode, cfg_signed} != prev_cfg) chk("cfg_idle", 64'(busy), 64'd0);
    prev_cfg = {cfg_mode, cfg_signed};
    if (!rst) begin
      exp_q.delete();
      mdl_open   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_vld", 64'(out_vld), 64'd1);
        chk("hold_psum", 64'(out_psum), 64'(prev_psum));
      end
      if (out_vld && !out_rdy) chk("stall_in_rdy", 64'(in_rdy), 64'd0);
      if (out_vld && out_rdy) begin
        exp_t e;
        got_q.push_back(out_psum);
        got_ovf_q.push_back(out_ovf);
        chk("exp_avail", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          $display("out psum=%06h ovf=%0d exp psum=%06h ovf=%0d", out_psum, out_ovf, e.psum, e.ovf);
          chk("psum", 64'(out_psum), 64'(e.psum));
          chk("ovf", 64'(out_ovf), 64'(e.ovf));
        end
      end
      if (in_vld && in_rdy) model_accept();
      prev_stall = out_vld && !out_rdy;
      prev_psum  = out_psum;
    end
  end

  // ---------------- downstream ready ----------------
  int rdy_mode = 0;   // 0 always ready, 1 random, 2 held low
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = ($urandom_range(0, 2) != 0);
      default: out_rdy = 1'b0;
    endcase
  end

  // ---------------- driver helpers ----------------
  function automatic logic [31:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  task automatic send(input logic [31:0] d, input logic [31:0] w,
                      input logic [23:0] ps, input logic last);
    bit ok;
    ok        = 1'b0;
    in_data   = d;
    in_weight = w;
    in_psum   = ps;
    in_last   = last;
    in_vld    = 1'b1;
    for (int waited = 0; waited < 500; waited++) begin
      @(negedge clk);
      if (in_rdy) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
    end
    in_vld = 1'b0;
    if (!ok) chk("accept", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("drain", 64'(busy), 64'd0);
  endtask

  logic [31:0] d1, w1;
  int          lat;

  initial begin
    rst        = 1'b0;
    cfg_mode   = 1'b0;
    cfg_signed = 1'b0;
    in_data    = '0;
    in_weight  = '0;
    in_psum    = '0;
    in_last    = 1'b0;
    in_vld     = 1'b0;
    out_rdy    = 1'b1;
    d1 = pack4(1, 2, 3, 4);
    w1 = pack4(5, 6, 7, 8);

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_psum", 64'(out_psum), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);

    // 1: PASS unsigned, latency
    got_q.delete();
    send(d1, w1, 24'd100, 1'b0);
    lat = 0;
    while (!out_vld && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("t1_latency", 64'(lat), 64'd4);
    drain();
    chk("t1_count", 64'(got_q.size()), 64'd1);
    chk("t1_psum", 64'(got_q[0]), 64'd170);

    // 2: PASS signed
    cfg_signed = 1'b1;
    got_q.delete();
    send(pack4(-1, -2, 3, 4), w1, 24'hFFFFF6, 1'b0);
    drain();
    chk("t2_psum", 64'(got_q[0]), 64'h00001A);

    // 3: ACCUM three-beat group
    cfg_mode   = 1'b1;
    cfg_signed = 1'b0;
    got_q.delete();
    send(d1, w1, 24'd5, 1'b0);
    send(d1, w1, 24'd999, 1'b0);
    send(d1, w1, 24'd999, 1'b1);
    drain();
    chk("t3_count", 64'(got_q.size()), 64'd1);
    chk("t3_psum", 64'(got_q[0]), 64'd215);

    // 4: backpressure mid-stream
    cfg_mode = 1'b0;
    got_q.delete();
    fork
      begin
        for (int i = 0; i < 6; i++)
          send($urandom, $urandom, 24'($urandom), 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        rdy_mode = 2;
        repeat (5) @(negedge clk);
        rdy_mode = 0;
      end
    join
    drain();
    chk("t4_count", 64'(got_q.size()), 64'd6);

    // 5: signed overflow at the top of the psum range
    cfg_signed = 1'b1;
    got_q.delete();
    got_ovf_q.delete();
    send(pack4(1, 0, 0, 0), pack4(1, 0, 0, 0), 24'h7FFFFF, 1'b0);
    drain();
`ifdef PE_MAC_SAT_EN
    chk("t5_psum", 64'(got_q[0]), 64'h7FFFFF);
    chk("t5_ovf", 64'(got_ovf_q[0]), 64'd1);
`else
    chk("t5_psum", 64'(got_q[0]), 64'h800000);
    chk("t5_ovf", 64'(got_ovf_q[0]), 64'd0);
`endif

    // 6: reset mid-group
    cfg_mode   = 1'b1;
    cfg_signed = 1'b0;
    send(d1, w1, 24'd1, 1'b0);
    send(d1, w1, 24'd2, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("t6_out_vld", 64'(out_vld), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    got_q.delete();
    send(d1, w1, 24'd0, 1'b1);
    drain();
    chk("t6_count", 64'(got_q.size()), 64'd1);
    chk("t6_psum", 64'(got_q[0]), 64'd70);

    // Randomized traffic across all mode / signedness combinations
    for (int ph = 0; ph < 4; ph++) begin
      drain();
      cfg_mode   = ph[1];
      cfg_signed = ph[0];
      rdy_mode   = 1;
      for (int n = 0; n < 50; n++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
        send($urandom, $urandom, 24'($urandom),
             (n == 49) || ($urandom_range(0, 3) == 0));
      end
      drain();
      rdy_mode = 0;
    end

    @(posedge clk); #1;
    chk("leftover", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
